// File: rtl/dec_pkg.sv
// Shared decode constants: MIPS32 opcode/funct/rt fields, ALU op encodings,
// control-bundle bit positions and the mult/div interlock state type.
package dec_pkg;

  localparam int DEC_CTRL_W = 22;

  localparam int CTRL_REGDST     = 0;
  localparam int CTRL_ALUSRC     = 1;
  localparam int CTRL_MEMTOREG   = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_JUMPREG    = 5;
  localparam int CTRL_REGWRITE   = 6;
  localparam int CTRL_HILOTOREG  = 7;
  localparam int CTRL_HIORLO     = 8;
  localparam int CTRL_HIWRITE    = 9;
  localparam int CTRL_LOWRITE    = 10;
  localparam int CTRL_IMMSE      = 11;
  localparam int CTRL_LINKREG    = 12;
  localparam int CTRL_LINKDATA   = 13;
  localparam int CTRL_ISMULT     = 14;
  localparam int CTRL_SIGNEDMULT = 15;
  localparam int CTRL_ISDIV      = 16;
  localparam int CTRL_SIGNEDDIV  = 17;
  localparam int CTRL_CP0TOREG   = 18;
  localparam int CTRL_CP0WRITE   = 19;
  localparam int CTRL_OVF_DETECT = 20;
  localparam int CTRL_MEMWE      = 21;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F, OP_COP0   = 6'h10, OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR    = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO  = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB   = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR   = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
  localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB  = 4'd2, ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_NOR  = 4'd6, ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8, ALU_SLL = 4'd9, ALU_SRL = 4'd10, ALU_SRA = 4'd11;
  localparam logic [3:0] ALU_LUI = 4'd12;

  typedef enum logic {ST_RUN = 1'b0, ST_MD_BUSY = 1'b1} md_state_e;

  // Entries that touch HI/LO must wait for an outstanding mult/div.
  function automatic logic is_hilo_class(input logic [DEC_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_ISMULT] | ctrl[CTRL_ISDIV] | ctrl[CTRL_HILOTOREG] |
           ctrl[CTRL_HIWRITE] | ctrl[CTRL_LOWRITE];
  endfunction

endpackage

// File: rtl/dec_core.sv
// Combinational MIPS32 integer decoder. Mult/div and HI/LO moves decode only
// when DEC_MULDIV_EN is defined; otherwise they are reported invalid.
module dec_core
  import dec_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [31:0]           instr,
  output logic [DEC_CTRL_W-1:0] ctrl,
  output logic [ALUOP_W-1:0]    aluop,
  output logic                  invalid
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [3:0] w_alu;
  logic       w_rtype;

  assign w_op    = instr[31:26];
  assign w_rs    = instr[25:21];
  assign w_rt    = instr[20:16];
  assign w_funct = instr[5:0];
  assign aluop   = ALUOP_W'(w_alu);

  always_comb begin
    ctrl    = '0;
    w_alu   = ALU_NOP;
    invalid = 1'b0;
    w_rtype = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        case (w_funct)
          F_SLL, F_SLLV: begin w_rtype = 1'b1; w_alu = ALU_SLL; end
          F_SRL, F_SRLV: begin w_rtype = 1'b1; w_alu = ALU_SRL; end
          F_SRA, F_SRAV: begin w_rtype = 1'b1; w_alu = ALU_SRA; end
          F_ADD:  begin w_rtype = 1'b1; w_alu = ALU_ADD; ctrl[CTRL_OVF_DETECT] = 1'b1; end
          F_SUB:  begin w_rtype = 1'b1; w_alu = ALU_SUB; ctrl[CTRL_OVF_DETECT] = 1'b1; end
          F_ADDU: begin w_rtype = 1'b1; w_alu = ALU_ADD;  end
          F_SUBU: begin w_rtype = 1'b1; w_alu = ALU_SUB;  end
          F_AND:  begin w_rtype = 1'b1; w_alu = ALU_AND;  end
          F_OR:   begin w_rtype = 1'b1; w_alu = ALU_OR;   end
          F_XOR:  begin w_rtype = 1'b1; w_alu = ALU_XOR;  end
          F_NOR:  begin w_rtype = 1'b1; w_alu = ALU_NOR;  end
          F_SLT:  begin w_rtype = 1'b1; w_alu = ALU_SLT;  end
          F_SLTU: begin w_rtype = 1'b1; w_alu = ALU_SLTU; end
          F_JR:   begin ctrl[CTRL_JUMP] = 1'b1; ctrl[CTRL_JUMPREG] = 1'b1; end
          F_JALR: begin
            w_rtype = 1'b1;
            ctrl[CTRL_JUMP] = 1'b1; ctrl[CTRL_JUMPREG] = 1'b1; ctrl[CTRL_LINKDATA] = 1'b1;
          end
`ifdef DEC_MULDIV_EN
          F_MFHI:  begin w_rtype = 1'b1; ctrl[CTRL_HILOTOREG] = 1'b1; ctrl[CTRL_HIORLO] = 1'b1; end
          F_MFLO:  begin w_rtype = 1'b1; ctrl[CTRL_HILOTOREG] = 1'b1; end
          F_MTHI:  ctrl[CTRL_HIWRITE] = 1'b1;
          F_MTLO:  ctrl[CTRL_LOWRITE] = 1'b1;
          F_MULT, F_MULTU: begin
            ctrl[CTRL_ISMULT] = 1'b1; ctrl[CTRL_SIGNEDMULT] = (w_funct == F_MULT);
            ctrl[CTRL_HIWRITE] = 1'b1; ctrl[CTRL_LOWRITE] = 1'b1;
          end
          F_DIV, F_DIVU: begin
            ctrl[CTRL_ISDIV] = 1'b1; ctrl[CTRL_SIGNEDDIV] = (w_funct == F_DIV);
            ctrl[CTRL_HIWRITE] = 1'b1; ctrl[CTRL_LOWRITE] = 1'b1;
          end
`endif
          default: invalid = 1'b1;
        endcase
        ctrl[CTRL_REGDST]   = ctrl[CTRL_REGDST] | w_rtype;
        ctrl[CTRL_REGWRITE] = ctrl[CTRL_REGWRITE] | w_rtype;
      end
      OP_REGIMM: begin
        case (w_rt)
          RT_BLTZ, RT_BGEZ: begin
            ctrl[CTRL_BRANCH] = 1'b1; ctrl[CTRL_IMMSE] = 1'b1; w_alu = ALU_SLT;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl[CTRL_BRANCH] = 1'b1; ctrl[CTRL_IMMSE] = 1'b1; w_alu = ALU_SLT;
            ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_LINKREG] = 1'b1; ctrl[CTRL_LINKDATA] = 1'b1;
          end
          default: invalid = 1'b1;
        endcase
      end
      OP_J:   ctrl[CTRL_JUMP] = 1'b1;
      OP_JAL: begin
        ctrl[CTRL_JUMP] = 1'b1; ctrl[CTRL_REGWRITE] = 1'b1;
        ctrl[CTRL_LINKREG] = 1'b1; ctrl[CTRL_LINKDATA] = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl[CTRL_BRANCH] = 1'b1; ctrl[CTRL_IMMSE] = 1'b1; w_alu = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_ALUSRC] = 1'b1; ctrl[CTRL_IMMSE] = 1'b1;
        ctrl[CTRL_OVF_DETECT] = (w_op == OP_ADDI);
        w_alu = (w_op == OP_SLTI) ? ALU_SLT : (w_op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      // Logical immediates are zero-extended, so immse stays clear.
      OP_ANDI: begin ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_ALUSRC] = 1'b1; w_alu = ALU_AND; end
      OP_ORI:  begin ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_ALUSRC] = 1'b1; w_alu = ALU_OR;  end
      OP_XORI: begin ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_ALUSRC] = 1'b1; w_alu = ALU_XOR; end
      OP_LUI:  begin ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_ALUSRC] = 1'b1; w_alu = ALU_LUI; end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_ALUSRC] = 1'b1;
        ctrl[CTRL_MEMTOREG] = 1'b1; ctrl[CTRL_IMMSE] = 1'b1; w_alu = ALU_ADD;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl[CTRL_ALUSRC] = 1'b1; ctrl[CTRL_IMMSE] = 1'b1;
        ctrl[CTRL_MEMWE] = 1'b1; w_alu = ALU_ADD;
      end
      OP_COP0: begin
        if (instr == INSTR_ERET) begin
          ctrl[CTRL_JUMP] = 1'b1;
        end else begin
          case (w_rs)
            RS_MFC0: begin ctrl[CTRL_REGWRITE] = 1'b1; ctrl[CTRL_CP0TOREG] = 1'b1; end
            RS_MTC0: ctrl[CTRL_CP0WRITE] = 1'b1;
            default: invalid = 1'b1;
          endcase
        end
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Decode-at-enqueue instruction queue with a mult/div HI/LO interlock.
// The interlock FSM exists only when DEC_MULDIV_EN is defined.
module decode_queue
  import dec_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALUOP_W = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [31:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DEC_CTRL_W-1:0]        out_ctrl,
  output logic [ALUOP_W-1:0]           out_aluop,
  output logic                         out_invalid,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  input  logic                         md_done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEC_CTRL_W-1:0] r_ctrl    [DEPTH];
  logic [ALUOP_W-1:0]    r_aluop   [DEPTH];
  logic                  r_invalid [DEPTH];
  logic [31:0]           r_instr   [DEPTH];
  logic [31:0]           r_pc      [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic [DEC_CTRL_W-1:0] w_dec_ctrl;
  logic [ALUOP_W-1:0]    w_dec_aluop;
  logic                  w_dec_invalid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_blocked;

  dec_core #(.ALUOP_W(ALUOP_W)) u_core (
    .instr   (in_instr),
    .ctrl    (w_dec_ctrl),
    .aluop   (w_dec_aluop),
    .invalid (w_dec_invalid)
  );

  assign in_ready    = (r_count < CW'(DEPTH));
  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign out_valid   = (r_count != '0) && !w_blocked;
  assign out_ctrl    = r_ctrl[r_rptr];
  assign out_aluop   = r_aluop[r_rptr];
  assign out_invalid = r_invalid[r_rptr];
  assign out_instr   = r_instr[r_rptr];
  assign out_pc      = r_pc[r_rptr];
  assign count       = r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl[i]    <= '0;
        r_aluop[i]   <= '0;
        r_invalid[i] <= 1'b0;
        r_instr[i]   <= 32'h0;
        r_pc[i]      <= 32'h0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ctrl[r_wptr]    <= w_dec_ctrl;
        r_aluop[r_wptr]   <= w_dec_aluop;
        r_invalid[r_wptr] <= w_dec_invalid;
        r_instr[r_wptr]   <= in_instr;
        r_pc[r_wptr]      <= in_pc;
        r_wptr            <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DEC_MULDIV_EN
  md_state_e r_state;

  assign w_blocked = (r_state == ST_MD_BUSY) && is_hilo_class(out_ctrl);

  // Flush leaves the interlock alone: the mult/div unit is still running.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:     r_state <= (w_pop && (out_ctrl[CTRL_ISMULT] || out_ctrl[CTRL_ISDIV]))
                               ? ST_MD_BUSY : ST_RUN;
        ST_MD_BUSY: r_state <= md_done ? ST_RUN : ST_MD_BUSY;
        default:    r_state <= ST_RUN;
      endcase
    end
  end
`else
  logic w_md_done_unused;

  assign w_md_done_unused = md_done;
  assign w_blocked        = 1'b0;
`endif

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of instruction-queue entries (power of 2, min 2).
REQ-002 SHALL have parameter ALUOP_W, default 4, meaning the aluop field width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: discards all queued instructions.
REQ-006 SHALL have port in_valid, input, 1 bit: fetch offers an instruction.
REQ-007 SHALL have port in_ready, output, 1 bit: the queue accepts an instruction.
REQ-008 SHALL have port in_instr, input, 32 bits: instruction word.
REQ-009 SHALL have port in_pc, input, 32 bits: instruction address.
REQ-010 SHALL have port out_valid, output, 1 bit: a decoded entry is available.
REQ-011 SHALL have port out_ready, input, 1 bit: execute consumes the entry.
REQ-012 SHALL have port out_ctrl, output, DEC_CTRL_W bits: packed control bundle.
REQ-013 SHALL have port out_aluop, output, ALUOP_W bits: ALU operation.
REQ-014 SHALL have port out_invalid, output, 1 bit: reserved/unknown instruction.
REQ-015 SHALL have port out_instr, output, 32 bits: the head instruction word.
REQ-016 SHALL have port out_pc, output, 32 bits: the head instruction address.
REQ-017 SHALL have port md_done, input, 1 bit: single-cycle pulse when the multiply/divide unit finishes.
REQ-018 SHALL have port count, output, clog2(DEPTH+1) bits: queue occupancy.

Function
REQ-019 Push on in_valid&&in_ready; in_ready SHALL equal (count<DEPTH) with no same-cycle pop bypass.
REQ-020 Decode SHALL occur at enqueue; ctrl, aluop, invalid, instr and pc SHALL be stored per entry.
REQ-021 Decode SHALL cover the MIPS32 integer set: R-type ALU, ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI, BEQ/BNE/BGEZ/BLTZ/BGEZAL/BLTZAL/BLEZ/BGTZ, J/JAL/JR/JALR, LB/LBU/LH/LHU/LW/SB/SH/SW, ERET/MFC0/MTC0; any other opcode SHALL give invalid=1 with ctrl=0 and aluop=0.
REQ-022 Latency: an instruction pushed into an empty queue SHALL appear with out_valid=1 on the next cycle.
REQ-023 Pop on out_valid&&out_ready; simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 Interlock FSM states: RUN, MD_BUSY; popping MULT/MULTU/DIV/DIVU SHALL move RUN->MD_BUSY; md_done SHALL move MD_BUSY->RUN.
REQ-025 In MD_BUSY, out_valid SHALL be 0 while the head is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO; other heads SHALL issue normally.
REQ-026 md_done in the same cycle as a blocked head SHALL release that head on the following cycle; md_done in RUN SHALL be ignored.
REQ-027 flush SHALL zero count and pointers next cycle and SHALL take priority over a same-cycle push and pop; flush SHALL NOT change the FSM state.
REQ-028 Empty queue SHALL drive out_valid=0; the out_* payload is don't-care while out_valid=0.

Reset
REQ-029 With resetn=0 at a clk edge: count=0, pointers=0, FSM=RUN, out_valid=0, in_ready=1, out_ctrl/out_aluop/out_invalid/out_instr/out_pc=0.
REQ-030 Reset SHALL override flush, push and pop; a reset asserted mid-MD_BUSY SHALL return the FSM to RUN.

Configuration
REQ-031 Macro DEC_MULDIV_EN defined: mult/div/HI-LO decode and the interlock FSM are present.
REQ-032 Macro DEC_MULDIV_EN absent: MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO SHALL decode invalid=1 with ctrl=0, the FSM is removed, and md_done is ignored.

Structure
REQ-033 Package dec_pkg SHALL hold opcode/funct/rt constants, aluop encodings, DEC_CTRL_W, and the ctrl bit-index constants (regdst, alusrc, memtoreg, branch, jump, jumpreg, regwrite, hilotoreg, hiorlo, hiwrite, lowrite, immse, linkreg, linkdata, ismult, signedmult, isdiv, signeddiv, cp0toreg, cp0write, ovf_detect, memwe).
REQ-034 The combinational decode SHALL be sub-module dec_core (instr -> ctrl, aluop, invalid); decode_queue holds the storage and FSM.

Verification
REQ-035 Push 0x20080005 (ADDI) into an empty queue -> next cycle out_valid=1 with regwrite=1, alusrc=1, immse=1, ovf_detect=1, aluop=add.
REQ-036 DEPTH=4, out_ready=0, push 5 instructions -> count=4 and in_ready=0 after the 4th push; 5th is not accepted; one pop -> in_ready=1.
REQ-037 Push 0x01090018 (MULT) then 0x00005012 (MFLO) with out_ready=1 -> MULT issues, MFLO is held with out_valid=0; md_done pulse -> MFLO issues the next cycle.
REQ-038 count=3, then flush together with in_valid=1 -> count=0 and out_valid=0 next cycle; the pushed word is dropped.
REQ-039 Push 0xFC000000 -> out_invalid=1, out_ctrl=0, out_aluop=0.
REQ-040 Build without DEC_MULDIV_EN, push 0x01090018 -> out_invalid=1, ismult=0, and the following instruction is not stalled.
